// File: rtl/freq_readout_pkg.sv
// Shared constants, FSM encoding and range helper for the frequency readout block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package freq_readout_pkg;

  localparam int NCH = 8;

  localparam logic [31:0] SYSCLK_MIN = 32'd21000000;
  localparam logic [31:0] SYSCLK_MAX = 32'd21700000;

  // Fixed channel order of the counter bus.
  localparam logic [2:0] CH_SYSCLK  = 3'd0;
  localparam logic [2:0] CH_READ    = 3'd1;
  localparam logic [2:0] CH_WRITE   = 3'd2;
  localparam logic [2:0] CH_PAWR    = 3'd3;
  localparam logic [2:0] CH_PARD    = 3'd4;
  localparam logic [2:0] CH_REFRESH = 3'd5;
  localparam logic [2:0] CH_CPUCLK  = 3'd6;
  localparam logic [2:0] CH_ROMSEL  = 3'd7;

  // MCU read-port addresses above the 32 snapshot bytes.
  localparam logic [5:0] ADDR_STATUS = 6'd32;
  localparam logic [5:0] ADDR_SYSOK  = 6'd33;
  localparam logic [5:0] ADDR_STICKY = 6'd34;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SCAN    = 2'd2,
    ST_READY   = 2'd3
  } state_t;

  // Inclusive unsigned window check on the sysclk count.
  function automatic logic sysclk_in_range(input logic [31:0] cnt);
    return (cnt >= SYSCLK_MIN) && (cnt <= SYSCLK_MAX);
  endfunction

endpackage

// File: rtl/freq_readout_mux.sv
// Registered byte select of snapshot/status for the MCU read port.
// Latency: 1 cycle from rd_strobe to rd_valid/rd_err.
// Backpressure: none; a strobe while busy is rejected with rd_err, rd_data holds.
//
// Ports: clk, rst_n; rd_strobe/rd_addr request; busy from the FSM;
//        shadow (8 x 32-bit snapshot), active_mask, sysclk_ok, sticky_dead sources;
//        rd_data/rd_valid/rd_err registered response.
module freq_readout_mux
  import freq_readout_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_strobe,
  input  logic [5:0]        rd_addr,
  input  logic              busy,
  input  logic [NCH*32-1:0] shadow,
  input  logic [NCH-1:0]    active_mask,
  input  logic              sysclk_ok,
  input  logic [NCH-1:0]    sticky_dead,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  logic [7:0] byte_sel;
  logic       rd_accept;

  assign rd_accept = rd_strobe && !busy;

  // Addresses 0..31: byte rd_addr[1:0] of channel rd_addr[4:2], LSB first.
  always_comb begin
    byte_sel = 8'h00;
    if (!rd_addr[5]) begin
      byte_sel = shadow[{rd_addr[4:0], 3'b000} +: 8];
    end else begin
      case (rd_addr)
        ADDR_STATUS: byte_sel = active_mask;
        ADDR_SYSOK:  byte_sel = {7'b0, sysclk_ok};
        ADDR_STICKY: byte_sel = sticky_dead;
        default:     byte_sel = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      rd_err   <= rd_strobe && busy;
      if (rd_accept) begin
        rd_data <= byte_sel;
      end
    end
  end

endmodule

// File: rtl/freq_readout.sv
// Snapshots eight 32-bit edge counts, scans them into a status byte, serves bytes to the MCU.
// Latency: busy for 9 cycles after snap_req; reads return 1 cycle after rd_strobe.
// Backpressure: snap_req ignored while busy; rd_strobe while busy answered with rd_err.
//
// Ports: clk, rst_n (async, active low); freq_in 8 x 32-bit counts (ch i at [32i+31:32i]);
//        snap_req capture pulse; rd_strobe/rd_addr read request; rd_data/rd_valid/rd_err;
//        busy, active_mask, sysclk_ok status.
// Build option FREQ_READOUT_STICKY_EN: adds clr_sticky input and a sticky_dead
//        register (channels ever seen dead), readable at address 34.
module freq_readout
  import freq_readout_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
`ifdef FREQ_READOUT_STICKY_EN
  input  logic              clr_sticky,
`endif
  input  logic [NCH*32-1:0] freq_in,
  input  logic              snap_req,
  input  logic              rd_strobe,
  input  logic [5:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              busy,
  output logic [NCH-1:0]    active_mask,
  output logic              sysclk_ok
);

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        scan_idx;
  logic [NCH*32-1:0] shadow;
  logic [31:0]       scan_word;
  logic [NCH-1:0]    mask_next;
  logic [NCH-1:0]    sticky_rd;
  logic              scan_last;

  assign scan_word = shadow[{scan_idx, 5'b00000} +: 32];
  assign scan_last = (state_q == ST_SCAN) && (scan_idx == CH_ROMSEL);
  assign busy      = (state_q == ST_CAPTURE) || (state_q == ST_SCAN);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY: if (snap_req) state_d = ST_CAPTURE;
      ST_CAPTURE:        state_d = ST_SCAN;
      ST_SCAN:           if (scan_last) state_d = ST_READY;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Mask including the bit being scanned this cycle; the sticky update at the
  // last scan step needs the final mask, not the registered one.
  always_comb begin
    mask_next = active_mask;
    if (state_q == ST_SCAN) begin
      mask_next[scan_idx] = (scan_word != 32'd0);
    end
  end

  // ---------------- snapshot + scan datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      active_mask <= '0;
      sysclk_ok   <= 1'b0;
      scan_idx    <= 3'd0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          shadow      <= freq_in;
          active_mask <= '0;
          sysclk_ok   <= 1'b0;
          scan_idx    <= 3'd0;
        end
        ST_SCAN: begin
          active_mask <= mask_next;
          if (scan_idx == CH_SYSCLK) begin
            sysclk_ok <= sysclk_in_range(scan_word);
          end
          scan_idx <= scan_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FREQ_READOUT_STICKY_EN
  logic [NCH-1:0] sticky_dead;

  // Clear has priority over a scan finishing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_dead <= '0;
    end else if (clr_sticky) begin
      sticky_dead <= '0;
    end else if (scan_last) begin
      sticky_dead <= sticky_dead | ~mask_next;
    end
  end

  assign sticky_rd = sticky_dead;
`else
  assign sticky_rd = '0;
`endif

  // ---------------- read port ----------------
  freq_readout_mux u_mux (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_strobe   (rd_strobe),
    .rd_addr     (rd_addr),
    .busy        (busy),
    .shadow      (shadow),
    .active_mask (active_mask),
    .sysclk_ok   (sysclk_ok),
    .sticky_dead (sticky_rd),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err)
  );

endmodule

// File: tb/tb_freq_readout.sv
module tb_freq_readout;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] freq_in = '0;
  logic         snap_req = 1'b0;
  logic         rd_strobe = 1'b0;
  logic [5:0]   rd_addr = 6'd0;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic         rd_err;
  logic         busy;
  logic [7:0]   active_mask;
  logic         sysclk_ok;
`ifdef FREQ_READOUT_STICKY_EN
  logic         clr_sticky = 1'b0;
`endif

  freq_readout dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef FREQ_READOUT_STICKY_EN
    .clr_sticky  (clr_sticky),
`endif
    .freq_in     (freq_in),
    .snap_req    (snap_req),
    .rd_strobe   (rd_strobe),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .busy        (busy),
    .active_mask (active_mask),
    .sysclk_ok   (sysclk_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  logic [7:0] last_rd = 8'h00;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } rd_vec_t;

  typedef struct {
    logic [31:0] cnt;
    bit          ok;
  } sys_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] v);
    freq_in[i*32 +: 32] = v;
  endtask

  // Record the response expected one cycle after the strobe being driven now.
  task automatic push_exp(input bit err, input logic [7:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.err = err;
    e.data = err ? last_rd : d;
    if (!err) last_rd = d;
    sb.push_back(e);
  endtask

  task automatic rd1(input logic [5:0] a, input logic [7:0] d);
    rd_addr = a;
    rd_strobe = 1'b1;
    push_exp(1'b0, d);
    tick();
    rd_strobe = 1'b0;
    tick();
  endtask

  task automatic snapshot();
    int n;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check("snap_busy_len", n, 9);
  endtask

  // Scoreboard: compare read responses in the cycle they are due.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("rd_valid", rd_valid, !e.err);
        check("rd_err", rd_err, e.err);
        check("rd_data", rd_data, e.data);
      end else if (rd_valid || rd_err) begin
        check("unexpected_rd", {rd_valid, rd_err}, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t  vec[16];
    sys_vec_t sys[7];
    int n;

    vec[0]  = '{6'd8,  8'h78};
    vec[1]  = '{6'd9,  8'h56};
    vec[2]  = '{6'd10, 8'h34};
    vec[3]  = '{6'd11, 8'h12};
    vec[4]  = '{6'd0,  8'h00};
    vec[5]  = '{6'd1,  8'h97};
    vec[6]  = '{6'd2,  8'h49};
    vec[7]  = '{6'd3,  8'h01};
    vec[8]  = '{6'd28, 8'h40};
    vec[9]  = '{6'd29, 8'h7E};
    vec[10] = '{6'd30, 8'h0B};
    vec[11] = '{6'd12, 8'h01};
    vec[12] = '{6'd32, 8'hFD};
    vec[13] = '{6'd33, 8'h01};
`ifdef FREQ_READOUT_STICKY_EN
    vec[14] = '{6'd34, 8'h02};
`else
    vec[14] = '{6'd34, 8'h00};
`endif
    vec[15] = '{6'd63, 8'h00};

    sys[0] = '{32'd21000000, 1'b1};
    sys[1] = '{32'd21700000, 1'b1};
    sys[2] = '{32'd21700001, 1'b0};
    sys[3] = '{32'd20999999, 1'b0};
    sys[4] = '{32'h01481A20, 1'b1};
    sys[5] = '{32'h01499700, 1'b1};
    sys[6] = '{32'hFFFFFFFF, 1'b0};

    // ---- reset state ----
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_mask", active_mask, 0);
    check("rst_sysok", sysclk_ok, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_err", rd_err, 0);
    rst_n = 1'b1;
    tick();
    rd1(6'd8, 8'h00);
    rd1(6'd32, 8'h00);

    // ---- main snapshot ----
    set_ch(0, 32'h01499700);
    set_ch(1, 32'h00000000);
    set_ch(2, 32'h12345678);
    set_ch(3, 32'd1);
    set_ch(4, 32'd2);
    set_ch(5, 32'd3);
    set_ch(6, 32'd4);
    set_ch(7, 32'h000B7E40);
    tick();
    snapshot();
    check("mask_main", active_mask, 8'hFD);
    check("sysok_main", sysclk_ok, 1);

    // Live input changes must not show through the read port.
    for (int i = 0; i < 8; i++) set_ch(i, 32'hA5A5A5A5 ^ i);
    for (int i = 0; i < 16; i++) begin
      rd_addr = vec[i].addr;
      rd_strobe = 1'b1;
      push_exp(1'b0, vec[i].data);
      tick();
    end
    rd_strobe = 1'b0;
    tick();

    // ---- read+snap same cycle, read while busy, snap while busy ----
    set_ch(2, 32'hCAFEF00D);
    rd_addr = 6'd8;
    rd_strobe = 1'b1;
    snap_req = 1'b1;
    push_exp(1'b0, 8'h78);
    tick();
    rd_strobe = 1'b0;
    snap_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      if (n == 3) begin
        rd_addr = 6'd9;
        rd_strobe = 1'b1;
        push_exp(1'b1, 8'h00);
      end
      if (n == 5) snap_req = 1'b1;
      n++;
      tick();
      rd_strobe = 1'b0;
      snap_req = 1'b0;
    end
    check("busy_len_resnap", n, 9);
    tick();
    rd1(6'd8, 8'h0D);
    rd1(6'd11, 8'hCA);

    // ---- sysclk window boundaries ----
    for (int i = 0; i < 7; i++) begin
      set_ch(0, sys[i].cnt);
      tick();
      snapshot();
      check("sysok_range", sysclk_ok, sys[i].ok);
      rd1(6'd33, {7'b0, sys[i].ok});
    end

    // ---- async reset mid-scan ----
    for (int i = 0; i < 8; i++) set_ch(i, 32'h100 + i);
    rd1(6'd0, 8'hFF);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mask", active_mask, 0);
    check("arst_sysok", sysclk_ok, 0);
    check("arst_rd_data", rd_data, 0);
    last_rd = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    rd1(6'd32, 8'h00);
    rd1(6'd0, 8'h00);

`ifdef FREQ_READOUT_STICKY_EN
    // ---- sticky dead channels ----
    set_ch(3, 32'd0);
    tick();
    snapshot();
    rd1(6'd34, 8'h08);
    set_ch(3, 32'd5);
    tick();
    snapshot();
    rd1(6'd34, 8'h08);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    rd1(6'd34, 8'h00);
`endif

    tick();
    tick();
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
